// File: rtl/obj_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obj_unpacker_pkg
// Purpose  : Shared definitions for the object unpacker. It holds the packed
//            object field offsets, the object type encodings and the unpacker
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package obj_unpacker_pkg;

    // Packed object word layout, with 16-bit coordinates.
    localparam int OBJ_W     = 145;
    localparam int X0_LSB    = 0;
    localparam int Y0_LSB    = 16;
    localparam int X1_LSB    = 32;
    localparam int Y1_LSB    = 48;
    localparam int X2_LSB    = 64;
    localparam int Y2_LSB    = 80;
    localparam int X3_LSB    = 96;
    localparam int Y3_LSB    = 112;
    localparam int COLOR_LSB = 128;
    localparam int COLOR_W   = 8;
    localparam int TYPE_LSB  = 142;
    localparam int TYPE_W    = 2;
    localparam int EN_BIT    = 144;

    // Object types. The type value is also the index of the final vertex.
    localparam logic [TYPE_W-1:0] OBJ_POINT = 2'd0;
    localparam logic [TYPE_W-1:0] OBJ_LINE  = 2'd1;
    localparam logic [TYPE_W-1:0] OBJ_TRI   = 2'd2;
    localparam logic [TYPE_W-1:0] OBJ_QUAD  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage : obj_unpacker_pkg
`default_nettype wire

// File: rtl/obj_vertex_mux.sv
`default_nettype none
// ============================================================================
// Module   : obj_vertex_mux
// Purpose  : Combinational vertex selector. It picks the (x, y) pair for
//            vertex idx out of the held coordinate block.
// Ports    : coords  in  8*COORD_W  x0,y0 .. x3,y3 packed as in the object word
//            idx     in  2          vertex index 0..3
//            x, y    out COORD_W    selected vertex coordinates
// Revision : 1.0 - initial release
// ============================================================================
module obj_vertex_mux
    import obj_unpacker_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic [8*COORD_W-1:0] coords,
    input  logic [1:0]           idx,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y
);

    always_comb begin
        x = '0;
        y = '0;
        case (idx)
            2'd0: begin
                x = coords[X0_LSB +: COORD_W];
                y = coords[Y0_LSB +: COORD_W];
            end
            2'd1: begin
                x = coords[X1_LSB +: COORD_W];
                y = coords[Y1_LSB +: COORD_W];
            end
            2'd2: begin
                x = coords[X2_LSB +: COORD_W];
                y = coords[Y2_LSB +: COORD_W];
            end
            default: begin
                x = coords[X3_LSB +: COORD_W];
                y = coords[Y3_LSB +: COORD_W];
            end
        endcase
    end

endmodule : obj_vertex_mux
`default_nettype wire

// File: rtl/obj_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : obj_unpacker
// Purpose  : Accepts one packed object word over a valid/ready handshake and
//            streams its type+1 vertices out, one point per cycle.
// Ports    : clk, rst              clock, asynchronous active-high reset
//            obj_in/valid/ready    object input handshake
//            pt_x/pt_y/pt_idx/pt_last/pt_color/pt_type/pt_valid/pt_ready
//                                  point output stream
//            busy                  an object is held and emission is running
//            obj_count             objects fully emitted (wraps)
//            drop_count            objects discarded by a clear enable bit
//                                  (saturates at 255)
// Revision : 1.0 - initial release
// ============================================================================
module obj_unpacker
    import obj_unpacker_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OBJ_W-1:0]     obj_in,
    input  logic                 obj_valid,
    output logic                 obj_ready,
    output logic [COORD_W-1:0]   pt_x,
    output logic [COORD_W-1:0]   pt_y,
    output logic [1:0]           pt_idx,
    output logic                 pt_last,
    output logic [COLOR_W-1:0]   pt_color,
    output logic [TYPE_W-1:0]    pt_type,
    output logic                 pt_valid,
    input  logic                 pt_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     obj_count,
    output logic [7:0]           drop_count
);

    localparam int c_COORDS_W = 8 * COORD_W;

    state_t                r_state;
    state_t                w_state_nxt;

    // Only the fields that can reach an output are held. The ignored
    // bits and the enable bit are not stored.
    logic [c_COORDS_W-1:0] r_coords;
    logic [COLOR_W-1:0]    r_color;
    logic [TYPE_W-1:0]     r_max;
    logic [1:0]            r_idx;
    logic [CNT_W-1:0]      r_obj_count;
    logic [7:0]            r_drop_count;

    logic                  w_last;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_drop;
    logic                  w_pt_hs;

    assign w_last    = (r_idx == r_max);
    assign w_accept  = obj_valid && obj_ready;
    assign w_capture = w_accept && obj_in[EN_BIT];
    assign w_drop    = w_accept && !obj_in[EN_BIT];
    assign w_pt_hs   = pt_valid && pt_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. An object accepted on the final-point handshake
    // re-enters EMIT directly, so back-to-back objects leave no bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_pt_hs && w_last) begin
                    w_state_nxt = w_capture ? ST_EMIT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        pt_valid  = 1'b0;
        busy      = 1'b0;
        obj_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                obj_ready = 1'b1;
            end
            ST_EMIT: begin
                pt_valid  = 1'b1;
                busy      = 1'b1;
                obj_ready = pt_ready && w_last;
            end
            default: begin
                obj_ready = 1'b0;
            end
        endcase
    end

    // Held object and vertex index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coords <= '0;
            r_color  <= '0;
            r_max    <= '0;
            r_idx    <= '0;
        end else if (w_capture) begin
            r_coords <= obj_in[c_COORDS_W-1:0];
            r_color  <= obj_in[COLOR_LSB +: COLOR_W];
            r_max    <= obj_in[TYPE_LSB +: TYPE_W];
            r_idx    <= '0;
        end else if (w_pt_hs && !w_last) begin
            r_idx    <= r_idx + 2'd1;
        end
    end

    // Counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obj_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pt_hs && w_last) begin
                r_obj_count <= r_obj_count + 1'b1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    obj_vertex_mux #(
        .COORD_W (COORD_W)
    ) u_vertex_mux (
        .coords (r_coords),
        .idx    (r_idx),
        .x      (pt_x),
        .y      (pt_y)
    );

    assign pt_idx     = r_idx;
    assign pt_last    = w_last;
    assign pt_color   = r_color;
    assign pt_type    = r_max;
    assign obj_count  = r_obj_count;
    assign drop_count = r_drop_count;

endmodule : obj_unpacker
`default_nettype wire

// File: tb/tb_obj_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_obj_unpacker
// Purpose  : Directed self-checking bench for obj_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obj_unpacker;

    logic          clk;
    logic          rst;
    logic [144:0]  obj_in;
    logic          obj_valid;
    logic          obj_ready;
    logic [15:0]   pt_x;
    logic [15:0]   pt_y;
    logic [1:0]    pt_idx;
    logic          pt_last;
    logic [7:0]    pt_color;
    logic [1:0]    pt_type;
    logic          pt_valid;
    logic          pt_ready;
    logic          busy;
    logic [15:0]   obj_count;
    logic [7:0]    drop_count;

    int n_checks;
    int n_errors;

    obj_unpacker #(
        .COORD_W (16),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .obj_in     (obj_in),
        .obj_valid  (obj_valid),
        .obj_ready  (obj_ready),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_idx     (pt_idx),
        .pt_last    (pt_last),
        .pt_color   (pt_color),
        .pt_type    (pt_type),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .busy       (busy),
        .obj_count  (obj_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [144:0] mk_obj(
        input logic en, input logic [1:0] typ, input logic [7:0] color,
        input logic [15:0] x0, input logic [15:0] y0,
        input logic [15:0] x1, input logic [15:0] y1,
        input logic [15:0] x2, input logic [15:0] y2,
        input logic [15:0] x3, input logic [15:0] y3);
        return {en, typ, 6'h2A, color, y3, x3, y2, x2, y1, x1, y0, x0};
    endfunction

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ex [4];
    logic [15:0] ey [4];
    logic [15:0] bx [5];
    logic [15:0] by [5];
    logic        rdy_pat [7];
    int          hs;
    int          gaps;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        obj_in    = '0;
        obj_valid = 1'b0;
        pt_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // ---------------- reset state ----------------
        check("rst_pt_valid", pt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_obj_ready", obj_ready, 1);
        check("rst_pt_x", pt_x, 0);
        check("rst_pt_y", pt_y, 0);
        check("rst_obj_count", obj_count, 0);
        check("rst_drop_count", drop_count, 0);

        // ---------------- quad, free-running ----------------
        ex = '{16'd1, 16'd3, 16'd5, 16'hFFF9};
        ey = '{16'd2, 16'd4, 16'd6, 16'hFFF8};
        obj_in    = mk_obj(1'b1, 2'd3, 8'hA5, ex[0], ey[0], ex[1], ey[1], ex[2], ey[2], ex[3], ey[3]);
        obj_valid = 1'b1;
        pt_ready  = 1'b1;
        tick();
        obj_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("quad_valid", pt_valid, 1);
            check("quad_busy", busy, 1);
            check("quad_idx", pt_idx, i);
            check("quad_x", pt_x, ex[i]);
            check("quad_y", pt_y, ey[i]);
            check("quad_last", pt_last, (i == 3) ? 1 : 0);
            check("quad_color", pt_color, 8'hA5);
            check("quad_type", pt_type, 2'd3);
            tick();
        end
        check("quad_done_valid", pt_valid, 0);
        check("quad_obj_count", obj_count, 1);

        // ---------------- point object with garbage in unused vertices ----------------
        obj_in    = mk_obj(1'b1, 2'd0, 8'h3C, 16'h7FFF, 16'h8000,
                           16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234, 16'h5678);
        obj_valid = 1'b1;
        tick();
        obj_valid = 1'b0;
        check("pt_valid", pt_valid, 1);
        check("pt_idx", pt_idx, 0);
        check("pt_last", pt_last, 1);
        check("pt_x", pt_x, 16'h7FFF);
        check("pt_y", pt_y, 16'h8000);
        check("pt_type", pt_type, 2'd0);
        tick();
        check("pt_done_valid", pt_valid, 0);
        check("pt_obj_count", obj_count, 2);

        // ---------------- back-to-back line then tri ----------------
        bx = '{16'd10, 16'd30, 16'd1, 16'd2, 16'd3};
        by = '{16'd20, 16'd40, 16'd1, 16'd2, 16'd3};
        obj_in    = mk_obj(1'b1, 2'd1, 8'h11, bx[0], by[0], bx[1], by[1], 16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB);
        obj_valid = 1'b1;
        tick();
        gaps = 0;
        for (int k = 0; k < 5; k++) begin
            if (pt_valid !== 1'b1) gaps = gaps + 1;
            check("b2b_x", pt_x, bx[k]);
            check("b2b_y", pt_y, by[k]);
            check("b2b_idx", pt_idx, (k < 2) ? k : k - 2);
            if (k == 0) begin
                check("b2b_ready_mid", obj_ready, 0);
                obj_in = mk_obj(1'b1, 2'd2, 8'h22, bx[2], by[2], bx[3], by[3], bx[4], by[4], 16'hCCCC, 16'hCCCC);
            end
            if (k == 1) begin
                check("b2b_ready_last", obj_ready, 1);
                check("b2b_last", pt_last, 1);
            end
            if (k == 2) begin
                check("b2b_tri_color", pt_color, 8'h22);
                obj_valid = 1'b0;
            end
            tick();
        end
        check("b2b_gaps", gaps, 0);
        check("b2b_done_valid", pt_valid, 0);
        check("b2b_obj_count", obj_count, 4);

        // ---------------- backpressure ----------------
        ex = '{16'd100, 16'd200, 16'd300, 16'd400};
        ey = '{16'hFF9C, 16'hFF38, 16'hFED4, 16'hFE70};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        obj_in    = mk_obj(1'b1, 2'd3, 8'h5A, ex[0], ey[0], ex[1], ey[1], ex[2], ey[2], ex[3], ey[3]);
        obj_valid = 1'b1;
        pt_ready  = 1'b0;
        tick();
        obj_valid = 1'b0;
        hs = 0;
        for (int c = 0; c < 7; c++) begin
            pt_ready = rdy_pat[c];
            #1;
            check("bp_valid", pt_valid, 1);
            check("bp_idx", pt_idx, hs);
            check("bp_x", pt_x, ex[hs]);
            check("bp_y", pt_y, ey[hs]);
            check("bp_last", pt_last, (hs == 3) ? 1 : 0);
            if (pt_valid && pt_ready) hs = hs + 1;
            tick();
        end
        check("bp_handshakes", hs, 4);
        check("bp_done_valid", pt_valid, 0);
        check("bp_obj_count", obj_count, 5);

        // ---------------- disabled objects ----------------
        pt_ready  = 1'b1;
        obj_in    = mk_obj(1'b0, 2'd3, 8'hFF, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
        obj_valid = 1'b1;
        gaps = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pt_valid !== 1'b0) gaps = gaps + 1;
            if (i == 0)   check("drop_first", drop_count, 1);
            if (i == 253) check("drop_254", drop_count, 254);
            if (i == 254) check("drop_sat", drop_count, 255);
        end
        obj_valid = 1'b0;
        check("drop_no_valid", gaps, 0);
        check("drop_final", drop_count, 255);
        check("drop_obj_count", obj_count, 5);

        // ---------------- reset mid-emission ----------------
        ex = '{16'd7, 16'd8, 16'd9, 16'd10};
        ey = '{16'd17, 16'd18, 16'd19, 16'd20};
        obj_in    = mk_obj(1'b1, 2'd3, 8'h77, ex[0], ey[0], ex[1], ey[1], ex[2], ey[2], ex[3], ey[3]);
        obj_valid = 1'b1;
        tick();
        obj_valid = 1'b0;
        tick();
        check("rm_idx1", pt_idx, 1);
        tick();
        check("rm_idx2", pt_idx, 2);
        rst = 1'b1;
        #1;
        check("rm_valid", pt_valid, 0);
        check("rm_busy", busy, 0);
        check("rm_obj_count", obj_count, 0);
        check("rm_drop_count", drop_count, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rm_ready", obj_ready, 1);
        obj_valid = 1'b1;
        tick();
        obj_valid = 1'b0;
        check("rm_new_valid", pt_valid, 1);
        check("rm_new_idx", pt_idx, 0);
        check("rm_new_x", pt_x, ex[0]);
        repeat (4) tick();
        check("rm_new_count", obj_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_obj_unpacker
`default_nettype wire

// File: doc/obj_unpacker.md
Name: obj_unpacker

Overview:
- Consumer end of the 145-bit object bus produced by the object-register/writeback stage.
- Accepts one packed object word over a valid/ready handshake and streams the object's vertices out one point per cycle, in order.
- Each point carries its index, a last flag, and the object's color and type.
- Feeds the downstream rasterizer/line-drawer front end; has no knowledge of transforms.

Parameters:
- COORD_W, 16, signed coordinate width; object field layout below assumes 16.
- CNT_W, 16, width of the completed-object counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- obj_in  in  145  packed object (layout below)
- obj_valid  in  1  obj_in is valid this cycle
- obj_ready  out  1  unpacker accepts obj_in this cycle
- pt_x  out  16  signed vertex x
- pt_y  out  16  signed vertex y
- pt_idx  out  2  vertex index 0..3
- pt_last  out  1  this point is the object's final vertex
- pt_color  out  8  object color
- pt_type  out  2  object type (0 point, 1 line, 2 tri, 3 quad)
- pt_valid  out  1  point outputs valid
- pt_ready  in  1  downstream accepts point
- busy  out  1  object held, emission in progress
- obj_count  out  CNT_W  completed (fully emitted) objects, wraps
- drop_count  out  8  objects discarded with enable bit clear, saturates at 255

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Object layout:
  - x0 [15:0], y0 [31:16], x1 [47:32], y1 [63:48], x2 [79:64], y2 [95:80], x3 [111:96], y3 [127:112].
  - color [135:128]; [141:136] ignored; type [143:142]; bit 144 is the object enable.
- Reset values: state IDLE; pt_valid 0, busy 0, obj_ready 1 once rst deasserts; pt_* data 0; obj_count 0; drop_count 0.
- State machine, IDLE / EMIT:
  - IDLE: obj_ready=1, pt_valid=0. On obj_valid&&obj_ready:
    - enable bit=1: capture the whole word into a holding register, set idx=0, max=type, go to EMIT.
    - enable bit=0: no capture, stay IDLE, drop_count+1 (saturating).
  - EMIT: pt_valid=1, busy=1. pt_x/pt_y are muxed from the held word by idx. pt_idx=idx, pt_last=(idx==max), color/type come from the held word.
    - On pt_valid&&pt_ready with !pt_last: idx+1.
    - On handshake with pt_last: obj_count+1; go to IDLE, unless a new enabled object is accepted the same cycle.
- Back-to-back:
  - obj_ready = IDLE || (EMIT && pt_ready && pt_last).
  - A new enabled object accepted on the last-point cycle is captured and emission restarts at idx 0 the next cycle, with zero bubble.
  - A disabled object accepted on that cycle is dropped, and the state returns to IDLE.
- Throughput and latency:
  - N=type+1 points per object in N cycles under constant pt_ready.
  - Latency is 1 cycle from object accept to first pt_valid.
- Stall: while pt_valid && !pt_ready, all pt_* outputs hold stable; idx and the held word are unchanged.
- Unused vertices: never emitted. Held fields beyond type are don't-care and must not leak to pt_x/pt_y.
- Arithmetic: no coordinate arithmetic. obj_count wraps modulo 2^CNT_W; drop_count saturates.
- Reset mid-emission: immediate return to IDLE; the held object is lost and counters are cleared.
- obj_valid while in EMIT and not on the last handshake: not accepted (obj_ready=0). The producer must hold obj_in stable.

Decomposition:
- Shared package holds:
  - field offset constants (X0_LSB..Y3_LSB, COLOR_LSB, TYPE_LSB, EN_BIT, OBJ_W=145);
  - type encodings (OBJ_POINT=0, OBJ_LINE=1, OBJ_TRI=2, OBJ_QUAD=3);
  - the state enum.
- Natural sub-module: obj_vertex_mux. It is combinational: held word + idx -> x, y.

Test Plan:
- Quad: obj_in {en=1, type=3, color=8'hA5, vertices (1,2),(3,4),(5,6),(-7,-8)}, pt_ready=1.
  - Required: 4 points, idx 0..3, pt_last only on idx 3 with (-7,-8).
  - Color A5 on every point; obj_count=1.
- Point object (type 0, (16'h7FFF,16'h8000)).
  - Required: single point with pt_last=1 and idx 0; obj_count+1.
  - x2..y3 garbage in the word does not appear on the outputs.
- Back-to-back: line (10,20),(30,40) then tri (1,1),(2,2),(3,3), with obj_valid held high.
  - Required: 5 consecutive pt_valid cycles with no gap.
  - obj_ready high on the line's last cycle; obj_count=2.
- Backpressure: quad with pt_ready toggled 1,0,0,1,0,1,1.
  - Required: outputs stable during stalls; exactly 4 handshakes with correct order.
- Disabled objects: en=0 object presented 300 times.
  - Required: no pt_valid; drop_count saturates at 255; obj_count unchanged.
- Reset mid-operation: assert rst after idx 1 of a quad.
  - Required: pt_valid=0 immediately; counters 0.
  - The next object emits from idx 0.
